ir_receiver_decoder: RTL and testbench
======================================

IR_RECEIVER_DECODER -- requirements
Module: ir_receiver_decoder

Interface
REQ-001 SHALL have parameter CARRIER_HALF, default 1389, meaning clocks per carrier half-period minus one (carrier period = 2*(CARRIER_HALF+1) clocks).
REQ-002 SHALL have parameter START_BURST, default 192, meaning nominal start-burst length in carrier periods.
REQ-003 SHALL have parameter SELECT_BURST, default 24, meaning nominal car-select burst length in carrier periods.
REQ-004 SHALL have parameter ASSERT_BURST, default 48, meaning nominal assert (bit=1) burst length in carrier periods.
REQ-005 SHALL have parameter DEASSERT_BURST, default 24, meaning nominal de-assert (bit=0) burst length in carrier periods.
REQ-006 SHALL have parameter TOL, default 4, meaning accepted +/- deviation in carrier periods for every burst class.
REQ-007 SHALL have parameter GAP_MAX, default 96, meaning the longest silence, in carrier periods, accepted between bursts.
REQ-008 SHALL have port CLK  input  1  system clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port RESET  input  1  reset, synchronous and active-low.
REQ-010 SHALL have port IR_IN  input  1  carrier-modulated IR line, asynchronous to CLK.
REQ-011 SHALL have port COMMAND  output  4  last valid command; bit0 right, bit1 left, bit2 backward, bit3 forward.
REQ-012 SHALL have port PACKET_VALID  output  1  one-cycle pulse when COMMAND is updated.
REQ-013 SHALL have port PACKET_ERROR  output  1  one-cycle pulse when a packet is aborted.
REQ-014 SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL synchronise IR_IN through two flip-flops; edge detection SHALL use the synchronised signal only.
REQ-016 SHALL count rising edges of the synchronised input during a burst in an 8-bit counter that saturates at 255.
REQ-017 SHALL declare a burst ended after 3*(CARRIER_HALF+1) clocks with no rising edge; the count SHALL be classified on the cycle after that.
REQ-018 SHALL classify a count as class X when |count - X_BURST| <= TOL; counts matching no class are invalid.
REQ-019 SHALL run state machine IDLE -> SELECT -> DATA -> TAIL: IDLE waits for a burst in the START class.
REQ-020 SHALL, in SELECT, accept only a SELECT-class burst and then enter DATA with bit index 0.
REQ-021 SHALL, in DATA, shift ASSERT as 1 and DEASSERT as 0 into the bit position given by bit index (LSB first); after index 3, enter TAIL.
REQ-022 SHALL, in TAIL, when silence reaches GAP_MAX periods, load COMMAND, pulse PACKET_VALID for one cycle, and return to IDLE.
REQ-023 SHALL, in SELECT/DATA, treat silence reaching GAP_MAX periods or any invalid or wrong-class burst as an abort: pulse PACKET_ERROR and return to IDLE.
REQ-024 SHALL, on abort by a burst classified START, enter SELECT directly (resynchronise) while still pulsing PACKET_ERROR.
REQ-025 SHALL treat any burst in TAIL as an abort with resynchronisation rules of REQ-024.
REQ-026 SHALL hold COMMAND unchanged on abort; the partial shift register SHALL never be visible on COMMAND.
REQ-027 SHALL use a silence counter of at least 24 bits; it SHALL saturate rather than wrap.
REQ-028 SHALL never assert PACKET_VALID and PACKET_ERROR in the same cycle.

Reset
REQ-029 SHALL, with RESET low at a rising CLK edge, force: state IDLE, COMMAND 4'b0000, PACKET_VALID 0, PACKET_ERROR 0, BUSY 0, all counters and synchronisers 0.
REQ-030 SHALL, on reset mid-packet, discard the packet with no PACKET_ERROR pulse.

Structure
REQ-031 SHALL take state encoding, burst-size constants and per-colour CARRIER_HALF values (yellow 1250, red 1389, green 1333, blue 1389) from shared package ir_packet_pkg, also used by the transmitter.
REQ-032 SHALL place synchroniser, edge detector, edge counter and silence timer in sub-module ir_burst_meter, emitting burst_done, burst_count and silence_periods.

Verification (bench overrides CARRIER_HALF=4)
REQ-033 Clean packet start 192, select 24, bits 48,24,48,24 -> after GAP_MAX, one PACKET_VALID, COMMAND=4'b0101.
REQ-034 Bursts of 188 and 196 for start and 52/20 for bits with command 4'b1111/0000 -> accepted; 187 or 197 start -> no BUSY exit, no pulse.
REQ-035 Select burst of 40 after valid start -> PACKET_ERROR once, COMMAND unchanged, state IDLE.
REQ-036 Silence of GAP_MAX periods after second data bit -> PACKET_ERROR once; a following clean packet with 4'b1000 -> COMMAND=4'b1000.
REQ-037 New start burst arriving during DATA -> PACKET_ERROR, then rest of that packet decodes correctly.
REQ-038 RESET low for one cycle during third data bit -> all outputs 0 next cycle, no PACKET_ERROR, next packet decodes.

Source files
------------

// File: rtl/ir_packet_pkg.sv
// Shared IR packet definitions: carrier timing per colour, burst lengths,
// decoder state encoding and the burst-class match helper.
package ir_packet_pkg;

   localparam int CH_YELLOW = 1250;
   localparam int CH_RED    = 1389;
   localparam int CH_GREEN  = 1333;
   localparam int CH_BLUE   = 1389;

   localparam int START_LEN    = 192;
   localparam int SELECT_LEN   = 24;
   localparam int ASSERT_LEN   = 48;
   localparam int DEASSERT_LEN = 24;
   localparam int BURST_TOL    = 4;
   localparam int GAP_LEN      = 96;

   localparam int SIL_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_DATA   = 2'd2,
      ST_TAIL   = 2'd3
   } ir_state_t;

   function automatic logic burst_match(input logic [7:0] count, input int nominal,
                                        input int tol);
      int diff;
      diff = int'(count) - nominal;
      return (diff <= tol) && (diff >= -tol);
   endfunction

endpackage

// File: rtl/ir_burst_meter.sv
// Front end of the IR receiver: synchronises the line, counts carrier rising
// edges within a burst, flags the end of a burst and measures silence.
module ir_burst_meter
   import ir_packet_pkg::*;
#(
   parameter int CARRIER_HALF = CH_RED
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ir,
   output logic             o_burst_done,
   output logic [7:0]       o_burst_count,
   output logic [SIL_W-1:0] o_silence_periods
);

   localparam int END_CLKS = 3 * (CARRIER_HALF + 1);
   localparam int PER_CLKS = 2 * (CARRIER_HALF + 1);
   localparam int END_W    = $clog2(END_CLKS);
   localparam int PER_W    = $clog2(PER_CLKS);

   logic             r_sync1, r_sync2, r_sync_d;
   logic             r_in_burst, r_done;
   logic [END_W-1:0] r_end_cnt;
   logic [PER_W-1:0] r_per_cnt;
   logic [7:0]       r_count;
   logic [SIL_W-1:0] r_sil;
   logic             w_rise;

   assign w_rise            = r_sync2 & ~r_sync_d;
   assign o_burst_done      = r_done;
   assign o_burst_count     = r_count;
   assign o_silence_periods = r_sil;

   // two-flop synchroniser plus a delayed copy for edge detection
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync1  <= i_ir;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   // saturating edge counter; burst ends after three half-periods without an edge
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_in_burst <= 1'b0;
         r_done     <= 1'b0;
         r_end_cnt  <= '0;
         r_count    <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_rise) begin
            r_in_burst <= 1'b1;
            r_end_cnt  <= END_W'(END_CLKS - 1);
            if (!r_in_burst)
               r_count <= 8'd1;
            else if (r_count != 8'hFF)
               r_count <= r_count + 8'd1;
         end else if (r_in_burst) begin
            if (r_end_cnt == '0) begin
               r_in_burst <= 1'b0;
               r_done     <= 1'b1;
            end else begin
               r_end_cnt <= r_end_cnt - 1'b1;
            end
         end
      end
   end

   // whole carrier periods since the last rising edge, saturating
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_per_cnt <= '0;
         r_sil     <= '0;
      end else if (w_rise) begin
         r_per_cnt <= PER_W'(PER_CLKS - 1);
         r_sil     <= '0;
      end else if (r_per_cnt == '0) begin
         r_per_cnt <= PER_W'(PER_CLKS - 1);
         if (r_sil != {SIL_W{1'b1}})
            r_sil <= r_sil + 1'b1;
      end else begin
         r_per_cnt <= r_per_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/ir_receiver_decoder.sv
// IR packet decoder: start, car-select and four data bursts, then a closing
// silence commits the 4-bit command.
//
//   state     | meaning
//   ST_IDLE   | waiting for a start-class burst
//   ST_SELECT | start seen, expecting the car-select burst
//   ST_DATA   | collecting data bits, LSB first
//   ST_TAIL   | four bits held, waiting for the closing silence
module ir_receiver_decoder
   import ir_packet_pkg::*;
#(
   parameter int CARRIER_HALF   = CH_RED,
   parameter int START_BURST    = START_LEN,
   parameter int SELECT_BURST   = SELECT_LEN,
   parameter int ASSERT_BURST   = ASSERT_LEN,
   parameter int DEASSERT_BURST = DEASSERT_LEN,
   parameter int TOL            = BURST_TOL,
   parameter int GAP_MAX        = GAP_LEN
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IR_IN,
   output logic [3:0] COMMAND,
   output logic       PACKET_VALID,
   output logic       PACKET_ERROR,
   output logic       BUSY
);

   logic             w_done;
   logic [7:0]       w_count;
   logic [SIL_W-1:0] w_sil;
   logic             w_is_start, w_is_select, w_is_assert, w_is_deassert, w_silent;

   ir_state_t  r_state, w_state_nxt;
   logic [3:0] r_shift, w_shift_nxt;
   logic [1:0] r_idx, w_idx_nxt;
   logic [3:0] r_cmd, w_cmd_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_error, w_error_nxt;

   ir_burst_meter #(.CARRIER_HALF(CARRIER_HALF)) u_meter (
      .i_clk             (CLK),
      .i_rst_n           (RESET),
      .i_ir              (IR_IN),
      .o_burst_done      (w_done),
      .o_burst_count     (w_count),
      .o_silence_periods (w_sil)
   );

   // select and de-assert share a nominal length, so classes are judged in state context
   assign w_is_start    = burst_match(w_count, START_BURST, TOL);
   assign w_is_select   = burst_match(w_count, SELECT_BURST, TOL);
   assign w_is_assert   = burst_match(w_count, ASSERT_BURST, TOL);
   assign w_is_deassert = burst_match(w_count, DEASSERT_BURST, TOL);
   assign w_silent      = (w_sil >= SIL_W'(GAP_MAX));

   assign COMMAND      = r_cmd;
   assign PACKET_VALID = r_valid;
   assign PACKET_ERROR = r_error;
   assign BUSY         = (r_state != ST_IDLE);

   // state, shift register, committed command and output pulses
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_cmd   <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_idx   <= w_idx_nxt;
         r_cmd   <= w_cmd_nxt;
         r_valid <= w_valid_nxt;
         r_error <= w_error_nxt;
      end
   end

   // next-state decode; an abort by a start burst resynchronises into SELECT
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_cmd_nxt   = r_cmd;
      w_valid_nxt = 1'b0;
      w_error_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_done && w_is_start)
               w_state_nxt = ST_SELECT;
         end
         ST_SELECT: begin
            if (w_done) begin
               if (w_is_select) begin
                  w_state_nxt = ST_DATA;
                  w_idx_nxt   = 2'd0;
               end else begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = w_is_start ? ST_SELECT : ST_IDLE;
               end
            end else if (w_silent) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (w_done) begin
               if (w_is_assert || w_is_deassert) begin
                  w_shift_nxt[r_idx] = w_is_assert;
                  if (r_idx == 2'd3)
                     w_state_nxt = ST_TAIL;
                  else
                     w_idx_nxt = r_idx + 2'd1;
               end else begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = w_is_start ? ST_SELECT : ST_IDLE;
               end
            end else if (w_silent) begin
               w_error_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_TAIL: begin
            if (w_done) begin
               w_error_nxt = 1'b1;
               w_state_nxt = w_is_start ? ST_SELECT : ST_IDLE;
            end else if (w_silent) begin
               w_cmd_nxt   = r_shift;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ir_receiver_decoder.sv
// Bench for ir_receiver_decoder: directed and randomized burst sequences
// compared against an abstract packet model.
module tb_ir_receiver_decoder;

   localparam int CH       = 4;
   localparam int HALF     = CH + 1;
   localparam int GAP_MAX  = 96;
   localparam int LONG_GAP = GAP_MAX + 5;
   localparam int N_START  = 192;
   localparam int N_SEL    = 24;
   localparam int N_AS     = 48;
   localparam int N_DE     = 24;
   localparam int N_TOL    = 4;

   logic       CLK   = 1'b0;
   logic       RESET = 1'b0;
   logic       IR_IN = 1'b0;
   logic [3:0] COMMAND;
   logic       PACKET_VALID, PACKET_ERROR, BUSY;

   int total = 0;
   int bad   = 0;

   int   seen_valid, seen_error;
   logic seen_busy;

   int         m_phase = 0;
   logic [3:0] m_bits  = '0;
   logic [3:0] m_cmd   = '0;
   int         m_valid, m_error;
   logic       m_busy;

   ir_receiver_decoder #(.CARRIER_HALF(CH)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .IR_IN        (IR_IN),
      .COMMAND      (COMMAND),
      .PACKET_VALID (PACKET_VALID),
      .PACKET_ERROR (PACKET_ERROR),
      .BUSY         (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // pulse monitor, sampled away from the rising edge
   always @(negedge CLK) begin
      if (PACKET_VALID || PACKET_ERROR)
         chk_val("excl_pulse", int'(PACKET_VALID & PACKET_ERROR), 0);
      if (PACKET_VALID) begin
         seen_valid++;
         chk_val("cmd_at_valid", int'(COMMAND), int'(m_cmd));
      end
      if (PACKET_ERROR) seen_error++;
      if (BUSY) seen_busy = 1'b1;
   end

   function automatic logic near(input int len, input int nominal);
      return (len >= nominal - N_TOL) && (len <= nominal + N_TOL);
   endfunction

   // packet-level reference: phase = bursts accepted so far (0 none .. 6 complete)
   function automatic void model_burst(input int len, input int gap_p);
      logic st, sel, as_b, de_b;
      st   = near(len, N_START);
      sel  = near(len, N_SEL);
      as_b = near(len, N_AS);
      de_b = near(len, N_DE);
      if (m_phase == 0) begin
         if (st) m_phase = 1;
      end else if (m_phase == 1 && sel) begin
         m_phase = 2;
      end else if (m_phase >= 2 && m_phase <= 5 && (as_b || de_b)) begin
         m_bits[m_phase-2] = as_b;
         m_phase++;
      end else begin
         m_error++;
         m_phase = st ? 1 : 0;
      end
      if (m_phase != 0) m_busy = 1'b1;
      if (gap_p + 1 >= GAP_MAX) begin
         if (m_phase == 6) begin
            m_valid++;
            m_cmd = m_bits;
         end else if (m_phase != 0) begin
            m_error++;
         end
         m_phase = 0;
      end
   endfunction

   task automatic carrier(input int n);
      for (int i = 0; i < n; i++) begin
         IR_IN = 1'b1;
         repeat (HALF) @(negedge CLK);
         IR_IN = 1'b0;
         repeat (HALF) @(negedge CLK);
      end
   endtask

   task automatic quiet(input int p);
      IR_IN = 1'b0;
      repeat (p * 2 * HALF) @(negedge CLK);
   endtask

   task automatic send_burst(input int len, input int gap_p);
      model_burst(len, gap_p);
      carrier(len);
      quiet(gap_p);
   endtask

   function automatic int jit(input int nominal, input logic rnd);
      if (!rnd) return nominal;
      return nominal + int'($urandom_range(0, 2 * N_TOL)) - N_TOL;
   endfunction

   task automatic send_packet(input logic [3:0] cmd, input logic rnd, input logic spoil);
      int bad_pos;
      bad_pos = spoil ? int'($urandom_range(0, 3)) : -1;
      send_burst(jit(N_START, rnd), int'($urandom_range(3, 12)));
      send_burst(jit(N_SEL, rnd), int'($urandom_range(3, 12)));
      for (int b = 0; b < 4; b++) begin
         int len;
         len = cmd[b] ? jit(N_AS, rnd) : jit(N_DE, rnd);
         if (b == bad_pos) len = int'($urandom_range(30, 40));
         send_burst(len, (b == 3) ? LONG_GAP : int'($urandom_range(3, 12)));
      end
   endtask

   task automatic begin_scn();
      seen_valid = 0;
      seen_error = 0;
      seen_busy  = 1'b0;
      m_valid    = 0;
      m_error    = 0;
      m_busy     = 1'b0;
   endtask

   task automatic end_scn(input string tag);
      chk_val({tag, "_valid"}, seen_valid, m_valid);
      chk_val({tag, "_error"}, seen_error, m_error);
      chk_val({tag, "_cmd"}, int'(COMMAND), int'(m_cmd));
      chk_val({tag, "_busy_end"}, int'(BUSY), 0);
      chk_val({tag, "_busy_seen"}, int'(seen_busy), int'(m_busy));
   endtask

   initial begin
      begin_scn();
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      chk_val("rst_cmd", int'(COMMAND), 0);
      chk_val("rst_valid", int'(PACKET_VALID), 0);
      chk_val("rst_error", int'(PACKET_ERROR), 0);
      chk_val("rst_busy", int'(BUSY), 0);
      RESET = 1'b1;
      repeat (5) @(negedge CLK);

      // clean packet 0101
      begin_scn();
      send_burst(192, 5); send_burst(24, 5);
      send_burst(48, 5); send_burst(24, 5); send_burst(48, 5); send_burst(24, LONG_GAP);
      end_scn("clean");

      // tolerance edges
      begin_scn();
      send_burst(188, 4); send_burst(24, 4);
      for (int b = 0; b < 4; b++) send_burst(52, (b == 3) ? LONG_GAP : 4);
      end_scn("tol_lo");
      begin_scn();
      send_burst(196, 4); send_burst(24, 4);
      for (int b = 0; b < 4; b++) send_burst(20, (b == 3) ? LONG_GAP : 4);
      end_scn("tol_hi");
      begin_scn();
      send_burst(187, LONG_GAP);
      end_scn("start187");
      begin_scn();
      send_burst(197, LONG_GAP);
      end_scn("start197");

      // wrong select length
      begin_scn();
      send_burst(192, 5); send_burst(40, LONG_GAP);
      end_scn("bad_sel");

      // silence after second bit, then clean 1000
      begin_scn();
      send_burst(192, 5); send_burst(24, 5); send_burst(48, 5); send_burst(24, LONG_GAP);
      end_scn("gap_abort");
      begin_scn();
      send_packet(4'b1000, 1'b0, 1'b0);
      end_scn("after_gap");

      // new start during data resynchronises
      begin_scn();
      send_burst(192, 5); send_burst(24, 5); send_burst(48, 5); send_burst(48, 5);
      send_packet(4'b0110, 1'b0, 1'b0);
      end_scn("resync");

      // reset during third data bit
      begin_scn();
      send_burst(192, 5); send_burst(24, 5); send_burst(48, 5); send_burst(24, 5);
      carrier(20);
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      chk_val("midrst_cmd", int'(COMMAND), 0);
      chk_val("midrst_valid", int'(PACKET_VALID), 0);
      chk_val("midrst_error", int'(PACKET_ERROR), 0);
      chk_val("midrst_busy", int'(BUSY), 0);
      m_phase = 0;
      m_cmd   = '0;
      carrier(28);
      quiet(LONG_GAP);
      send_packet(4'($urandom_range(0, 15)), 1'b1, 1'b0);
      end_scn("mid_reset");

      // randomized packets, some with a spoiled data burst
      for (int r = 0; r < 3; r++) begin
         begin_scn();
         send_packet(4'($urandom_range(0, 15)), 1'b1, ($urandom_range(0, 3) == 0));
         end_scn("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
